// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite motion engine.
// Channel state encoding, default widths and the reference saturating adder.
package sprite_pkg;

   localparam int unsigned OFS_W_DEF = 12;
   localparam int unsigned CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      MOVE,
      DONE
   } chan_state_e;

   // Add at OFS_W_DEF+1 bits, then clamp into the signed OFS_W_DEF range.
   function automatic logic signed [OFS_W_DEF-1:0] sat_add(
      input logic signed [OFS_W_DEF-1:0] a,
      input logic signed [OFS_W_DEF-1:0] b
   );
      logic signed [OFS_W_DEF:0] s;
      s = $signed({a[OFS_W_DEF-1], a}) + $signed({b[OFS_W_DEF-1], b});
      if (s[OFS_W_DEF] != s[OFS_W_DEF-1]) begin
         return s[OFS_W_DEF] ? {1'b1, {(OFS_W_DEF-1){1'b0}}} : {1'b0, {(OFS_W_DEF-1){1'b1}}};
      end
      return s[OFS_W_DEF-1:0];
   endfunction

endpackage

// File: rtl/sprite_motion_chan.sv
// One sprite channel: delay countdown, per-frame saturating linear motion, done/loop.
// All outputs are registered; configuration is latched on start.
module sprite_motion_chan
   import sprite_pkg::*;
#(
   parameter int unsigned OFS_W = OFS_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    tick_i,
   input  logic                    start_i,
   input  logic                    abort_i,
   input  logic                    loop_en_i,
   input  logic signed [OFS_W-1:0] cfg_h0_i,
   input  logic signed [OFS_W-1:0] cfg_v0_i,
   input  logic signed [OFS_W-1:0] cfg_dh_i,
   input  logic signed [OFS_W-1:0] cfg_dv_i,
   input  logic        [CNT_W-1:0] cfg_delay_i,
   input  logic        [CNT_W-1:0] cfg_len_i,
   output logic signed [OFS_W-1:0] hoffset_o,
   output logic signed [OFS_W-1:0] voffset_o,
   output logic                    busy_o,
   output logic                    done_o
);

   chan_state_e             state_q, state_d;
   logic signed [OFS_W-1:0] h_q, h_d, v_q, v_d;
   logic signed [OFS_W-1:0] h0_q, h0_d, v0_q, v0_d, dh_q, dh_d, dv_q, dv_d;
   logic        [CNT_W-1:0] delay_q, delay_d, len_q, len_d;
   logic        [CNT_W-1:0] dcnt_q, dcnt_d, mcnt_q, mcnt_d;
   logic                    busy_q, busy_d, done_q, done_d;

   function automatic logic signed [OFS_W-1:0] sat_step(
      input logic signed [OFS_W-1:0] a,
      input logic signed [OFS_W-1:0] b
   );
      logic signed [OFS_W:0] s;
      s = $signed({a[OFS_W-1], a}) + $signed({b[OFS_W-1], b});
      if (s[OFS_W] != s[OFS_W-1]) begin
         return s[OFS_W] ? {1'b1, {(OFS_W-1){1'b0}}} : {1'b0, {(OFS_W-1){1'b1}}};
      end
      return s[OFS_W-1:0];
   endfunction

   function automatic chan_state_e first_state(
      input logic [CNT_W-1:0] d,
      input logic [CNT_W-1:0] l
   );
      if (d != '0) return DELAY;
      if (l != '0) return MOVE;
      return DONE;
   endfunction

   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      v_d     = v_q;
      h0_d    = h0_q;
      v0_d    = v0_q;
      dh_d    = dh_q;
      dv_d    = dv_q;
      delay_d = delay_q;
      len_d   = len_q;
      dcnt_d  = dcnt_q;
      mcnt_d  = mcnt_q;
      done_d  = 1'b0;
      // abort beats start, and both beat a coincident frame tick
      if (abort_i) begin
         state_d = IDLE;
      end else if (start_i) begin
         h0_d    = cfg_h0_i;
         v0_d    = cfg_v0_i;
         dh_d    = cfg_dh_i;
         dv_d    = cfg_dv_i;
         delay_d = cfg_delay_i;
         len_d   = cfg_len_i;
         h_d     = cfg_h0_i;
         v_d     = cfg_v0_i;
         dcnt_d  = cfg_delay_i;
         mcnt_d  = cfg_len_i;
         state_d = first_state(cfg_delay_i, cfg_len_i);
      end else begin
         unique case (state_q)
            IDLE: ;
            DELAY: begin
               if (tick_i) begin
                  dcnt_d = dcnt_q - CNT_W'(1);
                  if (dcnt_q == CNT_W'(1)) state_d = (len_q != '0) ? MOVE : DONE;
               end
            end
            MOVE: begin
               if (tick_i) begin
                  h_d    = sat_step(h_q, dh_q);
                  v_d    = sat_step(v_q, dv_q);
                  mcnt_d = mcnt_q - CNT_W'(1);
                  if (mcnt_q == CNT_W'(1)) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end
               end
            end
            DONE: begin
               if (loop_en_i) begin
                  h_d     = h0_q;
                  v_d     = v0_q;
                  dcnt_d  = delay_q;
                  mcnt_d  = len_q;
                  state_d = first_state(delay_q, len_q);
               end
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d == DELAY) || (state_d == MOVE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         h_q     <= '0;
         v_q     <= '0;
         h0_q    <= '0;
         v0_q    <= '0;
         dh_q    <= '0;
         dv_q    <= '0;
         delay_q <= '0;
         len_q   <= '0;
         dcnt_q  <= '0;
         mcnt_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         v_q     <= v_d;
         h0_q    <= h0_d;
         v0_q    <= v0_d;
         dh_q    <= dh_d;
         dv_q    <= dv_d;
         delay_q <= delay_d;
         len_q   <= len_d;
         dcnt_q  <= dcnt_d;
         mcnt_q  <= mcnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign hoffset_o = h_q;
   assign voffset_o = v_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous motion engine: vsync synchronizer, frame tick and N_CH motion channels.
// Reset asserts asynchronously and is released through a two-flop synchronizer.
module sprite_motion_ctrl
   import sprite_pkg::*;
#(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned OFS_W = OFS_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic                    CLK100MHZ,
   input  logic                    CPU_RESETN,
   input  logic                    vsync_raw,
   input  logic [N_CH-1:0]         start,
   input  logic [N_CH-1:0]         abort,
   input  logic [N_CH-1:0]         loop_en,
   input  logic [N_CH*OFS_W-1:0]   cfg_h0,
   input  logic [N_CH*OFS_W-1:0]   cfg_v0,
   input  logic [N_CH*OFS_W-1:0]   cfg_dh,
   input  logic [N_CH*OFS_W-1:0]   cfg_dv,
   input  logic [N_CH*CNT_W-1:0]   cfg_delay,
   input  logic [N_CH*CNT_W-1:0]   cfg_len,
   output logic                    frame_tick,
   output logic [N_CH*OFS_W-1:0]   hoffset,
   output logic [N_CH*OFS_W-1:0]   voffset,
   output logic [N_CH-1:0]         busy,
   output logic [N_CH-1:0]         done
);

   logic rst_meta_q, rst_sync_q;
   logic vs_meta_q, vs_sync_q, vs_prev_q;
   logic tick_q, tick_d;

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end

   always_comb begin
      tick_d = vs_sync_q & ~vs_prev_q;
   end

   always_ff @(posedge CLK100MHZ or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         vs_meta_q <= 1'b0;
         vs_sync_q <= 1'b0;
         vs_prev_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         vs_meta_q <= vsync_raw;
         vs_sync_q <= vs_meta_q;
         vs_prev_q <= vs_sync_q;
         tick_q    <= tick_d;
      end
   end

   assign frame_tick = tick_q;

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      sprite_motion_chan #(
         .OFS_W (OFS_W),
         .CNT_W (CNT_W)
      ) u_chan (
         .clk_i       (CLK100MHZ),
         .rst_ni      (rst_sync_q),
         .tick_i      (tick_q),
         .start_i     (start[i]),
         .abort_i     (abort[i]),
         .loop_en_i   (loop_en[i]),
         .cfg_h0_i    (cfg_h0[i*OFS_W +: OFS_W]),
         .cfg_v0_i    (cfg_v0[i*OFS_W +: OFS_W]),
         .cfg_dh_i    (cfg_dh[i*OFS_W +: OFS_W]),
         .cfg_dv_i    (cfg_dv[i*OFS_W +: OFS_W]),
         .cfg_delay_i (cfg_delay[i*CNT_W +: CNT_W]),
         .cfg_len_i   (cfg_len[i*CNT_W +: CNT_W]),
         .hoffset_o   (hoffset[i*OFS_W +: OFS_W]),
         .voffset_o   (voffset[i*OFS_W +: OFS_W]),
         .busy_o      (busy[i]),
         .done_o      (done[i])
      );
   end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: expectations are queued with the stimulus
// and compared against the DUT once the corresponding frame or cycle has completed.
module tb_sprite_motion_ctrl;

   localparam int N_CH  = 4;
   localparam int OFS_W = 12;
   localparam int CNT_W = 8;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  vsync_raw = 1'b0;
   logic [N_CH-1:0]       start = '0, abort = '0, loop_en = '0;
   logic [N_CH*OFS_W-1:0] cfg_h0 = '0, cfg_v0 = '0, cfg_dh = '0, cfg_dv = '0;
   logic [N_CH*CNT_W-1:0] cfg_delay = '0, cfg_len = '0;
   logic                  frame_tick;
   logic [N_CH*OFS_W-1:0] hoffset, voffset;
   logic [N_CH-1:0]       busy, done;

   sprite_motion_ctrl #(
      .N_CH  (N_CH),
      .OFS_W (OFS_W),
      .CNT_W (CNT_W)
   ) dut (
      .CLK100MHZ  (clk),
      .CPU_RESETN (rst_n),
      .vsync_raw  (vsync_raw),
      .start      (start),
      .abort      (abort),
      .loop_en    (loop_en),
      .cfg_h0     (cfg_h0),
      .cfg_v0     (cfg_v0),
      .cfg_dh     (cfg_dh),
      .cfg_dv     (cfg_dv),
      .cfg_delay  (cfg_delay),
      .cfg_len    (cfg_len),
      .frame_tick (frame_tick),
      .hoffset    (hoffset),
      .voffset    (voffset),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef enum int {K_H, K_V, K_BUSY, K_DBIT, K_DONES, K_TICK} kind_e;
   typedef struct {
      string tag;
      kind_e kind;
      int    ch;
      int    val;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   done_cnt [N_CH];

   always @(negedge clk) begin
      for (int i = 0; i < N_CH; i++) if (done[i]) done_cnt[i]++;
   end

   task automatic check_eq(input string tag, input int obs, input int exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
      end
   endtask

   function automatic int observe(input kind_e k, input int ch);
      logic signed [OFS_W-1:0] s;
      case (k)
         K_H:     begin s = hoffset[ch*OFS_W +: OFS_W]; return int'(s); end
         K_V:     begin s = voffset[ch*OFS_W +: OFS_W]; return int'(s); end
         K_BUSY:  return int'(busy[ch]);
         K_DBIT:  return int'(done[ch]);
         K_DONES: return done_cnt[ch];
         default: return int'(frame_tick);
      endcase
   endfunction

   task automatic expect_val(input string tag, input kind_e k, input int ch, input int v);
      exp_t e;
      e.tag  = tag;
      e.kind = k;
      e.ch   = ch;
      e.val  = v;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_eq(e.tag, observe(e.kind, e.ch), e.val);
      end
   endtask

   task automatic expect_all_zero(input string tag);
      for (int c = 0; c < N_CH; c++) begin
         expect_val({tag, "_h"}, K_H, c, 0);
         expect_val({tag, "_v"}, K_V, c, 0);
         expect_val({tag, "_busy"}, K_BUSY, c, 0);
         expect_val({tag, "_done"}, K_DBIT, c, 0);
      end
      expect_val({tag, "_tick"}, K_TICK, 0, 0);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int ch, input int h0, input int v0, input int dh, input int dv,
                          input int dly, input int len);
      cfg_h0[ch*OFS_W +: OFS_W]    = h0[OFS_W-1:0];
      cfg_v0[ch*OFS_W +: OFS_W]    = v0[OFS_W-1:0];
      cfg_dh[ch*OFS_W +: OFS_W]    = dh[OFS_W-1:0];
      cfg_dv[ch*OFS_W +: OFS_W]    = dv[OFS_W-1:0];
      cfg_delay[ch*CNT_W +: CNT_W] = dly[CNT_W-1:0];
      cfg_len[ch*CNT_W +: CNT_W]   = len[CNT_W-1:0];
   endtask

   task automatic pulse(input logic [N_CH-1:0] st, input logic [N_CH-1:0] ab);
      start = st;
      abort = ab;
      cyc(1);
      start = '0;
      abort = '0;
   endtask

   // One vsync pulse; returns one cycle after frame_tick, when offsets have just updated.
   task automatic frame();
      bit seen = 0;
      cyc(4);
      vsync_raw = 1'b1;
      for (int k = 0; k < 10 && !seen; k++) begin
         cyc(1);
         if (frame_tick) seen = 1;
      end
      if (!seen) check_eq("tick_timeout", 0, 1);
      vsync_raw = 1'b0;
      cyc(1);
   endtask

   task automatic frames(input int n);
      repeat (n) frame();
   endtask

   initial begin
      // Reset state
      cyc(3);
      expect_all_zero("rst_hold");
      drain();
      rst_n = 1'b1;
      cyc(3);
      expect_all_zero("rst_rel");
      drain();

      // 1: ch0 linear motion, 60 frames
      set_cfg(0, -200, -40, 1, -6, 0, 60);
      pulse(4'b0001, 4'b0000);
      expect_val("t1_load_h", K_H, 0, -200);
      expect_val("t1_load_v", K_V, 0, -40);
      expect_val("t1_load_busy", K_BUSY, 0, 1);
      drain();
      frame();
      expect_val("t1_f1_h", K_H, 0, -199);
      expect_val("t1_f1_v", K_V, 0, -46);
      expect_val("t1_f1_tickw", K_TICK, 0, 0);
      drain();
      frames(58);
      expect_val("t1_f59_busy", K_BUSY, 0, 1);
      expect_val("t1_f59_dones", K_DONES, 0, 0);
      drain();
      frame();
      cyc(1);
      expect_val("t1_end_h", K_H, 0, -140);
      expect_val("t1_end_v", K_V, 0, -400);
      expect_val("t1_end_busy", K_BUSY, 0, 0);
      expect_val("t1_end_dones", K_DONES, 0, 1);
      drain();

      // 2: ch1 delay 5, then 3 moves of +10
      set_cfg(1, 0, 0, 10, 0, 5, 3);
      pulse(4'b0010, 4'b0000);
      for (int f = 1; f <= 8; f++) begin
         frame();
         expect_val($sformatf("t2_f%0d_h", f), K_H, 1, (f <= 5) ? 0 : (f - 5) * 10);
         expect_val($sformatf("t2_f%0d_dones", f), K_DONES, 1, 0);
         drain();
      end
      cyc(1);
      expect_val("t2_end_busy", K_BUSY, 1, 0);
      expect_val("t2_end_dones", K_DONES, 1, 1);
      drain();

      // 3: ch2 positive saturation on v
      set_cfg(2, 0, 2040, 0, 30, 0, 5);
      pulse(4'b0100, 4'b0000);
      for (int f = 1; f <= 5; f++) begin
         frame();
         expect_val($sformatf("t3_f%0d_v", f), K_V, 2, 2047);
         drain();
      end
      cyc(1);
      expect_val("t3_end_dones", K_DONES, 2, 1);
      expect_val("t3_end_busy", K_BUSY, 2, 0);
      drain();

      // 4: ch3 looping run of two +5 steps
      set_cfg(3, 0, 0, 5, 0, 0, 2);
      loop_en[3] = 1'b1;
      pulse(4'b1000, 4'b0000);
      for (int r = 0; r < 2; r++) begin
         frame();
         expect_val("t4_step1_h", K_H, 3, 5);
         drain();
         frame();
         expect_val("t4_step2_h", K_H, 3, 10);
         expect_val("t4_step2_done", K_DBIT, 3, 1);
         drain();
         cyc(1);
         expect_val("t4_reload_h", K_H, 3, 0);
         expect_val("t4_reload_busy", K_BUSY, 3, 1);
         expect_val("t4_dones", K_DONES, 3, r + 1);
         drain();
      end
      loop_en[3] = 1'b0;
      pulse(4'b0000, 4'b1000);
      expect_val("t4_abort_busy", K_BUSY, 3, 0);
      drain();

      // 5: restart ch0 mid-MOVE, then abort+start together
      set_cfg(0, 0, 0, 1, 0, 0, 10);
      pulse(4'b0001, 4'b0000);
      frames(2);
      expect_val("t5_mid_h", K_H, 0, 2);
      drain();
      set_cfg(0, 100, 0, 1, 0, 0, 10);
      pulse(4'b0001, 4'b0000);
      expect_val("t5_restart_h", K_H, 0, 100);
      expect_val("t5_restart_busy", K_BUSY, 0, 1);
      expect_val("t5_restart_dones", K_DONES, 0, 1);
      drain();
      frame();
      expect_val("t5_after_h", K_H, 0, 101);
      drain();
      set_cfg(0, 55, 0, 1, 0, 0, 10);
      pulse(4'b0001, 4'b0001);
      expect_val("t5_abst_busy", K_BUSY, 0, 0);
      expect_val("t5_abst_h", K_H, 0, 101);
      drain();
      frame();
      cyc(1);
      expect_val("t5_idle_h", K_H, 0, 101);
      expect_val("t5_idle_dones", K_DONES, 0, 1);
      drain();

      // 6: asynchronous reset in the middle of a MOVE on ch1
      set_cfg(1, 7, 0, 3, 0, 0, 20);
      pulse(4'b0010, 4'b0000);
      frames(2);
      expect_val("t6_pre_h", K_H, 1, 13);
      drain();
      #3;
      rst_n = 1'b0;
      #1;
      expect_all_zero("t6_async");
      drain();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(3);
      frame();
      expect_all_zero("t6_post");
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
